// File: rtl/gpio_pkg.sv
// Shared constants for the gpio input-conditioning / edge-interrupt slice.
package gpio_pkg;

    localparam int NGPIO_DEFAULT = 8;
    localparam int WIN_BITS      = 5;

    localparam logic [WIN_BITS-1:0] OFF_IN      = 5'h00;
    localparam logic [WIN_BITS-1:0] OFF_RISE_EN = 5'h04;
    localparam logic [WIN_BITS-1:0] OFF_FALL_EN = 5'h08;
    localparam logic [WIN_BITS-1:0] OFF_STATUS  = 5'h0C;

endpackage

// File: rtl/gpio_debounce.sv
// One pad bit: 2-FF synchroniser, stable-count debouncer, and a one-cycle
// rise/fall pulse that coincides with the edge where the debounced level updates.
module gpio_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int              CW       = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          update;

    // Update fires on the DB_CYCLES-th consecutive disagreeing cycle.
    assign update = (s2 != deb) && (cnt == CNT_LAST);
    assign rise   = update && s2;
    assign fall   = update && !s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (update) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_edge_irq.sv
// Pad-side conditioning for gpio: per-pin debounce, edge detection, W1C status
// with irq, and a small register window on the native memory bus.
module gpio_edge_irq
    import gpio_pkg::*;
#(
    parameter int          NGPIO     = NGPIO_DEFAULT,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0100,
    parameter int          DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_rdata,
    input  logic [NGPIO-1:0] pin_in,
    output logic [NGPIO-1:0] pin_sync,
    output logic             irq
);

    logic [NGPIO-1:0]    rise;
    logic [NGPIO-1:0]    fall;
    logic [NGPIO-1:0]    rise_en;
    logic [NGPIO-1:0]    fall_en;
    logic [NGPIO-1:0]    status;
    logic [NGPIO-1:0]    status_next;
    logic [WIN_BITS-1:0] off;
    logic                sel;
    logic                wr;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    genvar g;
    generate
        for (g = 0; g < NGPIO; g++) begin : g_pin
            gpio_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst_n (rst_n),
                .pin   (pin_in[g]),
                .deb   (pin_sync[g]),
                .rise  (rise[g]),
                .fall  (fall[g])
            );
        end
    endgenerate

    assign off          = mem_addr[WIN_BITS-1:0];
    assign sel          = mem_valid && (mem_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) && !mem_ready;
    assign wr           = sel && (mem_wstrb != 4'b0000);
    assign irq          = |status;
    assign unused_wdata = ^mem_wdata;

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_IN:      rd_mux[NGPIO-1:0] = pin_sync;
            OFF_RISE_EN: rd_mux[NGPIO-1:0] = rise_en;
            OFF_FALL_EN: rd_mux[NGPIO-1:0] = fall_en;
            OFF_STATUS:  rd_mux[NGPIO-1:0] = status;
            default:     rd_mux = '0;
        endcase
    end

    // Clear first, then set, so a new event beats a same-cycle W1C.
    always_comb begin
        status_next = status;
        if (wr && (off == OFF_STATUS)) begin
            for (int i = 0; i < NGPIO; i++) begin
                if (mem_wstrb[i/8] && mem_wdata[i]) begin
                    status_next[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NGPIO; i++) begin
            if ((rise[i] && rise_en[i]) || (fall[i] && fall_en[i])) begin
                status_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_en   <= '0;
            fall_en   <= '0;
            status    <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            status <= status_next;
            if (sel) begin
                mem_ready <= 1'b1;
                mem_rdata <= rd_mux;
            end else begin
                mem_ready <= 1'b0;
                mem_rdata <= '0;
            end
            if (wr) begin
                for (int i = 0; i < NGPIO; i++) begin
                    if (mem_wstrb[i/8]) begin
                        if (off == OFF_RISE_EN) rise_en[i] <= mem_wdata[i];
                        if (off == OFF_FALL_EN) fall_en[i] <= mem_wdata[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Directed bench for gpio_edge_irq: reset, debounce timing, edge irq, strobes,
// set/clear collision and bus handshake, with hand-computed expectations.
module tb_gpio_edge_irq;

    localparam logic [31:0] BASE = 32'h0300_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [7:0]  pin_in;
    logic [7:0]  pin_sync;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] r;
    logic [31:0] seen_rd;
    logic        seen;
    logic [3:0]  pat;

    always #5 clk = ~clk;

    gpio_edge_irq #(
        .NGPIO     (8),
        .BASE_ADDR (BASE),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .pin_in    (pin_in),
        .pin_sync  (pin_sync),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after ready has dropped.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = 1'b1;
        @(negedge clk);
        check("bus_ready", {31'b0, mem_ready}, 32'd1);
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        pin_in    = 8'hFF;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        // 1. reset
        repeat (10) @(negedge clk);
        check("rst_pin_sync", {24'b0, pin_sync}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_deb_early", {24'b0, pin_sync}, 32'h0);
        @(negedge clk);
        check("rst_deb_edge5", {24'b0, pin_sync}, 32'hFF);
        bus(BASE + 32'h0C, 32'h0, 4'h0, r);
        check("rst_status", r, 32'h0);
        check("rst_irq_after", {31'b0, irq}, 32'h0);
        pin_in = 8'h00;
        repeat (12) @(negedge clk);
        check("settle_low", {24'b0, pin_sync}, 32'h0);

        // 2. debounce
        pin_in = 8'h01;
        repeat (3) @(negedge clk);
        pin_in = 8'h00;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | pin_sync[0];
        end
        check("glitch_3cyc", {31'b0, seen}, 32'h0);
        pin_in = 8'h01;
        repeat (5) @(negedge clk);
        check("deb_hold", {24'b0, pin_sync}, 32'h0);
        @(negedge clk);
        check("deb_rise", {24'b0, pin_sync}, 32'h1);
        pin_in = 8'h00;
        bus(BASE + 32'h00, 32'h0, 4'h0, r);
        check("in_read", r, 32'h1);
        repeat (12) @(negedge clk);

        // 3. rise irq and W1C
        bus(BASE + 32'h04, 32'h01, 4'hF, r);
        pin_in = 8'h01;
        repeat (5) @(negedge clk);
        check("rise_pre_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("rise_pin", {24'b0, pin_sync}, 32'h1);
        check("rise_irq", {31'b0, irq}, 32'h1);
        bus(BASE + 32'h0C, 32'h0, 4'h0, r);
        check("rise_status", r, 32'h1);
        bus(BASE + 32'h0C, 32'h01, 4'hF, r);
        check("w1c_rd_old", r, 32'h1);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        bus(BASE + 32'h0C, 32'h0, 4'h0, r);
        check("w1c_status", r, 32'h0);
        pin_in = 8'h00;
        repeat (12) @(negedge clk);
        bus(BASE + 32'h0C, 32'h0, 4'h0, r);
        check("fall_no_set", r, 32'h0);
        check("fall_no_irq", {31'b0, irq}, 32'h0);

        // 4. byte strobes
        bus(BASE + 32'h08, 32'hAB, 4'h0, r);
        check("strb0_rd", r, 32'h0);
        bus(BASE + 32'h08, 32'h0, 4'h0, r);
        check("strb0_val", r, 32'h0);
        bus(BASE + 32'h08, 32'hAB, 4'h1, r);
        bus(BASE + 32'h08, 32'h0, 4'h0, r);
        check("strb1_val", r, 32'hAB);
        bus(BASE + 32'h08, 32'hFF00, 4'h2, r);
        bus(BASE + 32'h08, 32'h0, 4'h0, r);
        check("strb2_val", r, 32'hAB);
        bus(BASE + 32'h08, 32'h0, 4'hF, r);

        // 5. set beats same-cycle clear; clear of another bit still applies
        bus(BASE + 32'h04, 32'h03, 4'hF, r);
        pin_in = 8'h03;
        repeat (8) @(negedge clk);
        bus(BASE + 32'h0C, 32'h0, 4'h0, r);
        check("two_rise", r, 32'h3);
        pin_in = 8'h00;
        repeat (12) @(negedge clk);
        pin_in = 8'h01;
        repeat (5) @(negedge clk);
        check("coll_align", {24'b0, pin_sync}, 32'h0);
        check("coll_pre_irq", {31'b0, irq}, 32'h1);
        bus(BASE + 32'h0C, 32'h03, 4'hF, r);
        check("coll_irq", {31'b0, irq}, 32'h1);
        bus(BASE + 32'h0C, 32'h0, 4'h0, r);
        check("coll_status", r, 32'h1);
        bus(BASE + 32'h0C, 32'h01, 4'hF, r);

        // unmapped offset: reads 0, write ignored
        bus(BASE + 32'h10, 32'hFF, 4'hF, r);
        check("unmapped_rd", r, 32'h0);
        bus(BASE + 32'h04, 32'h0, 4'h0, r);
        check("unmapped_wr", r, 32'h3);

        // 6. handshake with valid held
        mem_addr  = BASE + 32'h0C;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        pat[3] = mem_ready;
        @(negedge clk);
        pat[2] = mem_ready;
        @(negedge clk);
        pat[1] = mem_ready;
        @(negedge clk);
        pat[0] = mem_ready;
        mem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hs_pattern", {28'b0, pat}, 32'h5);

        mem_addr  = 32'h0300_0000;
        mem_valid = 1'b1;
        seen      = 1'b0;
        seen_rd   = '0;
        repeat (4) begin
            @(negedge clk);
            seen    = seen | mem_ready;
            seen_rd = seen_rd | mem_rdata;
        end
        mem_valid = 1'b0;
        check("out_win_ready", {31'b0, seen}, 32'h0);
        check("out_win_rdata", seen_rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
